// File: rtl/occupancy_grid_rmw_pkg.sv
// occupancy_grid_rmw_pkg: grid geometry, update weights, cell/address types and FSM state encoding.
package occupancy_grid_rmw_pkg;
  localparam int WORD_SIZE = 8;
  localparam int GRID_WIDTH = 64;
  localparam int GRID_HEIGHT = 64;
  localparam int HIT_INC = 4;
  localparam int MISS_DEC = 1;
  localparam int SAT_MAX = 2 ** (WORD_SIZE - 1) - 1;
  localparam int SAT_MIN = -(2 ** (WORD_SIZE - 1));
  localparam int GRID_CELLS = GRID_WIDTH * GRID_HEIGHT;
  typedef logic signed [WORD_SIZE-1:0] word_t;
  typedef logic [$clog2(GRID_WIDTH)-1:0] width_index_t;
  typedef logic [$clog2(GRID_HEIGHT)-1:0] height_index_t;
  typedef logic [$clog2(GRID_CELLS)-1:0] address_t;
  typedef enum logic [2:0] {IDLE, READ, MODIFY, QUERY, CLEAR} occ_state_t;
endpackage

// File: rtl/occupancy_grid_rmw_if.sv
// occupancy_grid_rmw_if: update/query/clear channels; OCC_GRID_SAT_STATS_EN adds sat_count/sat_event.
interface occupancy_grid_rmw_if;
  import occupancy_grid_rmw_pkg::*;
  logic update_valid, update_ready, cell_is_free;
  width_index_t update_x, query_x;
  height_index_t update_y, query_y;
  logic query_valid, query_ready, result_valid;
  word_t result_value;
  logic clear_start, busy, clear_done;
`ifdef OCC_GRID_SAT_STATS_EN
  logic [15:0] sat_count;
  logic sat_event;
`endif
  modport slave (
    input update_valid, update_x, update_y, cell_is_free, query_valid, query_x, query_y, clear_start,
    output update_ready, query_ready, result_valid, result_value, busy, clear_done
`ifdef OCC_GRID_SAT_STATS_EN
    , output sat_count, sat_event
`endif
  );
  modport master (
    output update_valid, update_x, update_y, cell_is_free, query_valid, query_x, query_y, clear_start,
    input update_ready, query_ready, result_valid, result_value, busy, clear_done
`ifdef OCC_GRID_SAT_STATS_EN
    , input sat_count, sat_event
`endif
  );
endinterface

// File: rtl/occupancy_grid_rmw_sat_update.sv
// sat_update: log-odds hit/miss step computed two bits wide, then clamped to [SAT_MIN, SAT_MAX].
module sat_update #(
  parameter int WORD_SIZE = 8,
  parameter int HIT_INC = 4,
  parameter int MISS_DEC = 1,
  parameter int SAT_MIN = -(2 ** (WORD_SIZE - 1)),
  parameter int SAT_MAX = 2 ** (WORD_SIZE - 1) - 1
) (
  input logic signed [WORD_SIZE-1:0] value,
  input logic free,
  output logic signed [WORD_SIZE-1:0] result,
  output logic clamped
);
  localparam int W = WORD_SIZE + 2;
  localparam logic signed [W-1:0] HI = W'(SAT_MAX);
  localparam logic signed [W-1:0] LO = W'(SAT_MIN);
  logic signed [W-1:0] ext, sum;
  assign ext = W'(value);
  assign sum = free ? ext - W'(MISS_DEC) : ext + W'(HIT_INC);
  assign clamped = sum > HI || sum < LO;
  assign result = sum > HI ? WORD_SIZE'(SAT_MAX) : sum < LO ? WORD_SIZE'(SAT_MIN) : sum[WORD_SIZE-1:0];
endmodule

// File: rtl/ram_2d.sv
// ram_2d: single-port synchronous RAM, 1-cycle read latency, contents not reset.
module ram_2d #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH = 4096
) (
  input logic clk,
  input logic en,
  input logic we,
  input logic [$clog2(DEPTH)-1:0] addr,
  input logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [WORD_SIZE-1:0] mem [DEPTH];
  // rdata only moves on reads so it stays valid across a following write cycle
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/occupancy_grid_rmw.sv
// occupancy_grid_rmw: serialised saturating RMW log-odds grid with query and clear sweep; OCC_GRID_SAT_STATS_EN adds clamp statistics.
module occupancy_grid_rmw
  import occupancy_grid_rmw_pkg::*;
(
  input logic clock,
  input logic reset,
  occupancy_grid_rmw_if.slave bus
);
  occ_state_t state;
  logic ready_q, free_q, clamped, ram_en, ram_we, upd_go, qry_go, clr_go, upd_ok, qry_ok;
  address_t addr_q, clr_addr, ram_addr, upd_addr, qry_addr;
  word_t rdata, mod_value;
  assign bus.update_ready = ready_q && !bus.clear_start;
  assign bus.query_ready = ready_q && !bus.clear_start && !bus.update_valid;
  assign bus.busy = state != IDLE;
  assign clr_go = state == IDLE && bus.clear_start;
  assign upd_go = bus.update_valid && bus.update_ready;
  assign qry_go = bus.query_valid && bus.query_ready;
  assign upd_ok = int'(bus.update_x) < GRID_WIDTH && int'(bus.update_y) < GRID_HEIGHT;
  assign qry_ok = int'(bus.query_x) < GRID_WIDTH && int'(bus.query_y) < GRID_HEIGHT;
  assign upd_addr = address_t'(int'(bus.update_y) * GRID_WIDTH + int'(bus.update_x));
  assign qry_addr = address_t'(int'(bus.query_y) * GRID_WIDTH + int'(bus.query_x));
  // reset gates the write so an aborted sweep leaves no further cells touched
  assign ram_we = !reset && (state == MODIFY || state == CLEAR);
  assign ram_en = ram_we || (!reset && ((upd_go && upd_ok) || (qry_go && qry_ok)));
  assign ram_addr = state == CLEAR ? clr_addr : state == MODIFY ? addr_q : upd_go ? upd_addr : qry_addr;
  ram_2d #(.WORD_SIZE(WORD_SIZE), .DEPTH(GRID_CELLS)) u_ram (
    .clk(clock), .en(ram_en), .we(ram_we), .addr(ram_addr),
    .wdata(state == MODIFY ? mod_value : '0), .rdata(rdata)
  );
  sat_update #(
    .WORD_SIZE(WORD_SIZE), .HIT_INC(HIT_INC), .MISS_DEC(MISS_DEC), .SAT_MIN(SAT_MIN), .SAT_MAX(SAT_MAX)
  ) u_sat (.value(rdata), .free(free_q), .result(mod_value), .clamped(clamped));
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      ready_q <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_value <= '0;
      bus.clear_done <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      bus.clear_done <= 1'b0;
      case (state)
        IDLE: begin
          state <= clr_go ? CLEAR : upd_go && upd_ok ? READ : qry_go && qry_ok ? QUERY : IDLE;
          ready_q <= !(clr_go || (upd_go && upd_ok) || (qry_go && qry_ok));
          clr_addr <= '0;
          addr_q <= upd_addr;
          free_q <= bus.cell_is_free;
          // out-of-range query answers 0 without touching the RAM
          if (qry_go && !qry_ok) begin
            bus.result_valid <= 1'b1;
            bus.result_value <= '0;
          end
        end
        READ: state <= MODIFY;
        MODIFY: begin
          state <= IDLE;
          ready_q <= 1'b1;
        end
        QUERY: begin
          state <= IDLE;
          ready_q <= 1'b1;
          bus.result_valid <= 1'b1;
          bus.result_value <= rdata;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == address_t'(GRID_CELLS - 1)) begin
            state <= IDLE;
            ready_q <= 1'b1;
            bus.clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef OCC_GRID_SAT_STATS_EN
  always_ff @(posedge clock)
    if (reset || clr_go) bus.sat_count <= '0;
    else if (state == MODIFY && clamped && bus.sat_count != 16'hFFFF) bus.sat_count <= bus.sat_count + 16'd1;
  assign bus.sat_event = state == MODIFY && clamped && !reset;
`else
  logic sat_unused;
  assign sat_unused = clamped;
`endif
endmodule
